// File: rtl/node_port_buffer_pkg.sv
// Shared router package: stream word geometry and header helpers.
// Used by node_port_buffer and the node router.
package node_port_buffer_pkg;

  localparam int DATA_W = 128;
  localparam int NET_W = 4;
  localparam int STREAM_W = DATA_W + NET_W;

  function automatic int stream_w(
    input int dw,
    input int nw
  );
    return dw + nw;
  endfunction

  function automatic logic [NET_W-1:0] get_naddr(
    input logic [STREAM_W-1:0] word
  );
    return word[STREAM_W-1 -: NET_W];
  endfunction

endpackage

// File: rtl/port_fifo_mem.sv
// DEPTH x WIDTH storage for the port buffer.
// Synchronous write, asynchronous read at the read pointer.
module port_fifo_mem #(
  parameter int WIDTH = 132,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    wa,
  input  logic [WIDTH-1:0] wd,
  input  logic [AW-1:0]    ra,
  output logic [WIDTH-1:0] rd
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[wa] <= wd;
  end

  assign rd = mem[ra];

endmodule

// File: rtl/node_port_buffer.sv
// Per-port ingress FIFO in front of one router stream.
// Define NODE_PORT_BUFFER_STATS_EN to add hwm / stall_cnt outputs.
module node_port_buffer
  import node_port_buffer_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_W,
  parameter int NET_WIDTH = NET_W,
  parameter int DEPTH = 4,
  localparam int STREAM_WIDTH = stream_w(DATA_WIDTH, NET_WIDTH),
  localparam int CNT_WIDTH = $clog2(DEPTH) + 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [STREAM_WIDTH-1:0] in_stream,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [STREAM_WIDTH-1:0] out_stream,
  output logic [NET_WIDTH-1:0]    out_naddr,
`ifdef NODE_PORT_BUFFER_STATS_EN
  output logic [CNT_WIDTH-1:0]    hwm,
  output logic [15:0]             stall_cnt,
`endif
  output logic [CNT_WIDTH-1:0]    count
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [CNT_WIDTH-1:0] FULL = CNT_WIDTH'(DEPTH);

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CNT_WIDTH-1:0] count_next;
  logic [STREAM_WIDTH-1:0] head;
  logic push;
  logic pop;

  assign in_ready = (count != FULL);
  assign out_valid = (count != '0);
  assign push = in_valid && in_ready;
  assign pop = out_valid && out_ready;

  port_fifo_mem #(
    .WIDTH(STREAM_WIDTH),
    .DEPTH(DEPTH)
  ) u_mem (
    .clk(clk),
    .we(push),
    .wa(wr_ptr),
    .wd(in_stream),
    .ra(rd_ptr),
    .rd(head)
  );

  always_comb begin
    count_next = count;
    unique case ({push, pop})
      2'b10: count_next = count + 1'b1;
      2'b01: count_next = count - 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      count <= count_next;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Stale memory is masked so the router never sees old words.
  assign out_stream = out_valid ? head : '0;

  if (DATA_WIDTH == DATA_W && NET_WIDTH == NET_W) begin : g_def
    assign out_naddr = get_naddr(out_stream);
  end else begin : g_gen
    assign out_naddr = out_stream[STREAM_WIDTH-1 -: NET_WIDTH];
  end

`ifdef NODE_PORT_BUFFER_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      hwm <= '0;
      stall_cnt <= '0;
    end else begin
      if (count_next > hwm) hwm <= count_next;
      if (in_valid && !in_ready && stall_cnt != 16'hFFFF)
        stall_cnt <= stall_cnt + 1'b1;
    end
  end
`endif

  a_count_bound: assert property (
    @(posedge clk) disable iff (rst) count <= FULL
  );

endmodule

// File: tb/tb_node_port_buffer.sv
// Scoreboard bench for node_port_buffer: directed cases plus random traffic.
// Stats outputs are checked when NODE_PORT_BUFFER_STATS_EN is defined.
module tb_node_port_buffer;

  localparam int DW = 128;
  localparam int NW = 4;
  localparam int SW = DW + NW;
  localparam int DEPTH = 4;
  localparam int CW = $clog2(DEPTH) + 1;

  logic clk = 1'b0;
  logic rst;
  logic in_valid;
  logic in_ready;
  logic [SW-1:0] in_stream;
  logic out_valid;
  logic out_ready;
  logic [SW-1:0] out_stream;
  logic [NW-1:0] out_naddr;
  logic [CW-1:0] count;
`ifdef NODE_PORT_BUFFER_STATS_EN
  logic [CW-1:0] hwm;
  logic [15:0] stall_cnt;
`endif

  int n_chk = 0;
  int n_fail = 0;

  logic [SW-1:0] exp_q[$];
  bit started = 0;
  int hwm_m = 0;
  int stall_m = 0;

  always #5 clk = ~clk;

  node_port_buffer #(
    .DATA_WIDTH(DW),
    .NET_WIDTH(NW),
    .DEPTH(DEPTH)
  ) dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_stream(in_stream),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_stream(out_stream),
    .out_naddr(out_naddr),
`ifdef NODE_PORT_BUFFER_STATS_EN
    .hwm(hwm),
    .stall_cnt(stall_cnt),
`endif
    .count(count)
  );

  task automatic chk(
    input string name,
    input logic [SW-1:0] act,
    input logic [SW-1:0] req
  );
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h at %0t", name, act, req, $time);
    end
  endtask

  // Reference model: a plain queue of accepted words, updated on each edge.
  always @(posedge clk) begin
    int sz;
    sz = exp_q.size();
    if (rst) begin
      exp_q.delete();
      hwm_m = 0;
      stall_m = 0;
      started = 1;
    end else if (started) begin
      if (in_valid && sz == DEPTH && stall_m < 65535) stall_m++;
      if (out_ready && sz > 0) void'(exp_q.pop_front());
      if (in_valid && sz < DEPTH) exp_q.push_back(in_stream);
      if (exp_q.size() > hwm_m) hwm_m = exp_q.size();
    end
  end

  // Monitor: compare the presented head and status against the scoreboard.
  always @(negedge clk) begin
    logic [SW-1:0] h;
    int sz;
    if (started) begin
      sz = exp_q.size();
      h = (sz > 0) ? exp_q[0] : '0;
      chk("count", SW'(count), SW'(sz));
      chk("in_ready", SW'(in_ready), SW'(sz != DEPTH));
      chk("out_valid", SW'(out_valid), SW'(sz != 0));
      chk("out_stream", out_stream, h);
      chk("out_naddr", SW'(out_naddr), SW'(h[SW-1 -: NW]));
`ifdef NODE_PORT_BUFFER_STATS_EN
      chk("hwm", SW'(hwm), SW'(hwm_m));
      chk("stall_cnt", SW'(stall_cnt), SW'(stall_m));
`endif
    end
  end

  task automatic step(
    input logic iv,
    input logic [SW-1:0] d,
    input logic ordy,
    input logic r
  );
    in_valid = iv;
    in_stream = d;
    out_ready = ordy;
    rst = r;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [SW-1:0] mk(input int na, input int pl);
    logic [SW-1:0] w;
    w = '0;
    w[SW-1 -: NW] = NW'(na);
    w[31:0] = pl;
    return w;
  endfunction

  function automatic logic [SW-1:0] rnd_word();
    logic [159:0] t;
    t = {$urandom, $urandom, $urandom, $urandom, $urandom};
    return t[SW-1:0];
  endfunction

  initial begin
    logic [SW-1:0] w;
    logic [SW-1:0] bp;
    bit hold;
    bit iv;
    in_valid = 0;
    in_stream = '0;
    out_ready = 0;
    rst = 1;

    // Single word
    step(0, '0, 0, 1);
    step(0, '0, 0, 1);
    step(0, '0, 1, 0);
    chk("rst_count", SW'(count), SW'(0));
    chk("rst_in_ready", SW'(in_ready), SW'(1));
    chk("rst_out_valid", SW'(out_valid), SW'(0));
    chk("rst_out_stream", out_stream, '0);
    step(1, mk(4'hA, 32'h1234), 1, 0);
    chk("sw_count1", SW'(count), SW'(1));
    chk("sw_naddr", SW'(out_naddr), SW'(4'hA));
    step(0, '0, 1, 0);
    chk("sw_count0", SW'(count), SW'(0));

    // Fill then drain with a held fifth word
    for (int i = 0; i < 4; i++) step(1, mk(i + 1, 32'h100 + i), 0, 0);
    chk("fill_count", SW'(count), SW'(4));
    chk("fill_in_ready", SW'(in_ready), SW'(0));
    step(1, mk(4'h9, 32'h999), 0, 0);
    step(1, mk(4'h9, 32'h999), 0, 0);
    chk("fill_held", SW'(count), SW'(4));
    step(1, mk(4'h9, 32'h999), 1, 0);
    chk("fill_pop_refuse", SW'(count), SW'(3));
    step(1, mk(4'h9, 32'h999), 1, 0);
    chk("fill_accept", SW'(count), SW'(3));
    for (int i = 0; i < 4; i++) step(0, '0, 1, 0);
    chk("fill_drained", SW'(count), SW'(0));

    // Back-pressure hold
    bp = mk(4'h5, 32'hBEEF);
    step(1, bp, 0, 0);
    for (int i = 0; i < 3; i++) begin
      step(0, '0, 0, 0);
      chk("bp_stable", out_stream, bp);
    end
    step(0, '0, 1, 0);
    chk("bp_popped", SW'(count), SW'(0));

    // Streaming with wrap-around
    for (int i = 0; i < 20; i++) begin
      step(1, mk(i, 32'hC000 + i), 1, 0);
      chk("stream_count", SW'(count), SW'(1));
    end
    step(0, '0, 1, 0);

    // Reset mid-operation with in_valid present
    for (int i = 0; i < 3; i++) step(1, mk(4'h3, i), 0, 0);
    chk("mid_count3", SW'(count), SW'(3));
    step(1, mk(4'h7, 32'h77), 0, 1);
    chk("mid_count", SW'(count), SW'(0));
    chk("mid_out_valid", SW'(out_valid), SW'(0));
    chk("mid_out_stream", out_stream, '0);
    chk("mid_in_ready", SW'(in_ready), SW'(1));
    step(0, '0, 1, 0);
    chk("mid_not_accepted", SW'(count), SW'(0));

    // Stats scenario: fill, stall five cycles, drain
    step(0, '0, 0, 1);
    for (int i = 0; i < 4; i++) step(1, mk(4'hE, i), 0, 0);
    for (int i = 0; i < 5; i++) step(1, mk(4'hF, 32'hF), 0, 0);
    step(1, mk(4'hF, 32'hF), 1, 0);
    step(1, mk(4'hF, 32'hF), 1, 0);
    for (int i = 0; i < 4; i++) step(0, '0, 1, 0);
`ifdef NODE_PORT_BUFFER_STATS_EN
    chk("stats_hwm", SW'(hwm), SW'(4));
    chk("stats_stall", SW'(stall_cnt), SW'(6));
    step(0, '0, 0, 1);
    chk("stats_hwm_rst", SW'(hwm), SW'(0));
    chk("stats_stall_rst", SW'(stall_cnt), SW'(0));
`endif

    // Random traffic respecting the upstream hold rule
    hold = 0;
    w = '0;
    for (int i = 0; i < 400; i++) begin
      if (!hold) begin
        iv = ($urandom_range(3) != 0);
        w = rnd_word();
      end else begin
        iv = 1;
      end
      hold = iv && (exp_q.size() == DEPTH);
      step(iv, w, ($urandom_range(2) != 0), 0);
    end
    for (int i = 0; i < 6; i++) step(0, '0, 1, 0);
    chk("final_empty", SW'(count), SW'(0));

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
